// File: rtl/ata_pio_engine_if.sv
// Request/response handshake between the controller sequencer and the PIO engine.
interface ata_pio_engine_if;
   logic        bus_en;
   logic        bus_wr;
   logic [3:0]  bus_addr;
   logic [15:0] bus_din;
   logic [15:0] bus_dout;
   logic        bus_wait;

   modport master (output bus_en, bus_wr, bus_addr, bus_din,
                   input  bus_dout, bus_wait);
   modport slave  (input  bus_en, bus_wr, bus_addr, bus_din,
                   output bus_dout, bus_wait);
endinterface

// File: rtl/ata_pio_engine.sv
// ATA PIO mode-0 cycle engine: turns one register request into a timed
// CS/address -> strobe -> hold -> recovery sequence on the disk pins.
module ata_pio_engine #(
   parameter int T_SETUP       = 4,
   parameter int T_STROBE      = 15,
   parameter int T_HOLD        = 2,
   parameter int T_RECOVER     = 10,
   parameter int IORDY_EN      = 1,
   parameter int IORDY_TIMEOUT = 62
) (
   input  logic                clk,
   input  logic                reset,
   ata_pio_engine_if.slave     bus,
   inout  wire  [15:0]         ata_d,
   output logic [2:0]          ata_a,
   output logic                ata_cs0_n,
   output logic                ata_cs1_n,
   output logic                ata_dior_n,
   output logic                ata_diow_n,
   input  logic                ata_iordy
);
   localparam int MAX_SH = (T_SETUP > T_HOLD)     ? T_SETUP  : T_HOLD;
   localparam int MAX_SR = (T_STROBE > T_RECOVER) ? T_STROBE : T_RECOVER;
   localparam int MAXT   = (MAX_SH > MAX_SR)      ? MAX_SH   : MAX_SR;
   localparam int CW_R   = $clog2(MAXT + 1);
   localparam int CW     = (CW_R > 0) ? CW_R : 1;
   localparam int EW_R   = $clog2(IORDY_TIMEOUT + 1);
   localparam int EW     = (EW_R > 0) ? EW_R : 1;

   localparam logic [CW-1:0] SETUP_LAST   = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] STROBE_LAST  = CW'(T_STROBE - 1);
   localparam logic [CW-1:0] HOLD_LAST    = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] RECOVER_LAST = CW'(T_RECOVER - 1);
   localparam logic [EW-1:0] EXT_MAX      = EW'(IORDY_TIMEOUT);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [EW-1:0] ext_q, ext_d;
   logic          wr_q, wr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic          oe_q, oe_d;
   logic [2:0]    a_q, a_d;
   logic          cs0_n_q, cs0_n_d, cs1_n_q, cs1_n_d;
   logic          dior_n_q, dior_n_d, diow_n_q, diow_n_d;
   logic [15:0]   dout_q, dout_d;
   logic          iordy_s1_q, iordy_s2_q;
   logic [15:0]   d_in_q;
   logic          bus_wait;

   assign ata_d        = oe_q ? wdata_q : 16'hzzzz;
   assign ata_a        = a_q;
   assign ata_cs0_n    = cs0_n_q;
   assign ata_cs1_n    = cs1_n_q;
   assign ata_dior_n   = dior_n_q;
   assign ata_diow_n   = diow_n_q;
   assign bus.bus_dout = dout_q;
   assign bus.bus_wait = bus_wait;

   // Next-state and pin sequencing for one PIO cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ext_d    = ext_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      oe_d     = oe_q;
      a_d      = a_q;
      cs0_n_d  = cs0_n_q;
      cs1_n_d  = cs1_n_q;
      dior_n_d = dior_n_q;
      diow_n_d = diow_n_q;
      dout_d   = dout_q;
      bus_wait = 1'b1;
      case (state_q)
         IDLE: begin
            bus_wait = bus.bus_en;
            cnt_d    = '0;
            ext_d    = '0;
            if (bus.bus_en) begin
               wr_d    = bus.bus_wr;
               wdata_d = bus.bus_din;
               a_d     = bus.bus_addr[2:0];
               cs0_n_d = ~bus.bus_addr[3];
               cs1_n_d = bus.bus_addr[3];
               oe_d    = bus.bus_wr;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d    = '0;
               dior_n_d = wr_q;
               diow_n_d = ~wr_q;
               state_d  = STROBE;
            end else cnt_d = cnt_q + 1'b1;
         end
         STROBE: begin
            if (cnt_q != STROBE_LAST) cnt_d = cnt_q + 1'b1;
            else if (IORDY_EN != 0 && !iordy_s2_q && ext_q < EXT_MAX) ext_d = ext_q + 1'b1;
            else begin
               // Timeout falls through here too: complete with whatever is on the bus.
               if (!wr_q) dout_d = d_in_q;
               dior_n_d = 1'b1;
               diow_n_d = 1'b1;
               cnt_d    = '0;
               state_d  = HOLD;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               cs0_n_d = 1'b1;
               cs1_n_d = 1'b1;
               oe_d    = 1'b0;
               state_d = RECOVER;
            end else cnt_d = cnt_q + 1'b1;
         end
         RECOVER: begin
            if (cnt_q == RECOVER_LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else cnt_d = cnt_q + 1'b1;
         end
         DONE: begin
            bus_wait = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State/pin registers; reset aborts any cycle in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ext_q    <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         oe_q     <= 1'b0;
         a_q      <= '0;
         cs0_n_q  <= 1'b1;
         cs1_n_q  <= 1'b1;
         dior_n_q <= 1'b1;
         diow_n_q <= 1'b1;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ext_q    <= ext_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         oe_q     <= oe_d;
         a_q      <= a_d;
         cs0_n_q  <= cs0_n_d;
         cs1_n_q  <= cs1_n_d;
         dior_n_q <= dior_n_d;
         diow_n_q <= diow_n_d;
         dout_q   <= dout_d;
      end
   end

   // IORDY is asynchronous to clk; two-flop synchronizer, idles ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         iordy_s1_q <= 1'b1;
         iordy_s2_q <= 1'b1;
      end else begin
         iordy_s1_q <= ata_iordy;
         iordy_s2_q <= iordy_s1_q;
      end
   end

   // Data bus sampled every clock; a read captures from this register.
   always_ff @(posedge clk) begin
      if (reset) d_in_q <= '0;
      else       d_in_q <= ata_d;
   end
endmodule

// File: tb/tb_ata_pio_engine.sv
// Self-checking bench for ata_pio_engine: vector table of single cycles,
// plus back-to-back, IORDY extension/timeout, mid-cycle reset sequences.
module tb_ata_pio_engine;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ata_iordy = 1'b1;
   wire  [15:0] ata_d;
   logic [2:0]  ata_a;
   logic        ata_cs0_n, ata_cs1_n, ata_dior_n, ata_diow_n;
   logic [15:0] dev_word = 16'h0000;

   ata_pio_engine_if bus_if();

   ata_pio_engine dut (
      .clk(clk), .reset(reset), .bus(bus_if.slave), .ata_d(ata_d),
      .ata_a(ata_a), .ata_cs0_n(ata_cs0_n), .ata_cs1_n(ata_cs1_n),
      .ata_dior_n(ata_dior_n), .ata_diow_n(ata_diow_n), .ata_iordy(ata_iordy)
   );

   // Device model: drives its current word while DIOR_n is low.
   assign ata_d = (!ata_dior_n) ? dev_word : 16'hzzzz;

   always #10 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [15:0] din;
      logic [15:0] dev;
      logic [4:0]  exp_csa;   // {cs0_n, cs1_n, a}
      logic [15:0] exp_dout;
   } vec_t;

   vec_t        vecs[5];
   logic [15:0] sb[$];
   logic [15:0] model_dout;
   int          checks = 0;
   int          fails  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pop_chk(input string nm);
      if (sb.size() == 0) chk({nm, "_sb_empty"}, 1, 0);
      else chk({nm, "_dout"}, {16'h0, bus_if.bus_dout}, {16'h0, sb.pop_front()});
   endtask

   // One request from IDLE (called at a negedge); iordy_mode 0 = ready,
   // 1 = low for 20 clocks from request, 2 = held low for the whole cycle.
   task automatic run_cycle(input logic wr, input logic [3:0] addr, input logic [15:0] din,
                            input logic [15:0] dev, input logic [4:0] exp_csa,
                            input int iordy_mode, input int exp_strb, input int exp_wait,
                            input string nm);
      int k, wcnt, rd_lo, wr_lo, oe_cnt, oe_ok;
      logic seen;
      logic [4:0] csa;
      k = 0; wcnt = 0; rd_lo = 0; wr_lo = 0; oe_cnt = 0; oe_ok = 0; seen = 0; csa = '0;
      dev_word = dev;
      ata_iordy = (iordy_mode == 0);
      bus_if.bus_en = 1'b1; bus_if.bus_wr = wr; bus_if.bus_addr = addr; bus_if.bus_din = din;
      @(posedge clk);
      do begin
         @(negedge clk);
         k++;
         if (k == 1) bus_if.bus_en = 1'b0;
         if (iordy_mode == 1 && k == 20) ata_iordy = 1'b1;
         if (bus_if.bus_wait) wcnt++;
         if (!ata_dior_n) rd_lo++;
         if (!ata_diow_n) wr_lo++;
         if (dut.oe_q) begin
            oe_cnt++;
            if (ata_d == din) oe_ok++;
         end
         if (!seen && (!ata_dior_n || !ata_diow_n)) begin
            seen = 1'b1;
            csa = {ata_cs0_n, ata_cs1_n, ata_a};
         end
      end while (bus_if.bus_wait && k < 300);
      if (k >= 300) chk({nm, "_timeout"}, 1, 0);
      chk({nm, "_wait_len"}, wcnt, exp_wait);
      chk({nm, "_strobe_len"}, wr ? wr_lo : rd_lo, exp_strb);
      chk({nm, "_other_strobe"}, wr ? rd_lo : wr_lo, 0);
      chk({nm, "_cs_addr"}, {27'h0, csa}, {27'h0, exp_csa});
      chk({nm, "_oe_clocks"}, oe_cnt, wr ? 21 : 0);
      chk({nm, "_oe_data"}, oe_ok, wr ? 21 : 0);
      pop_chk(nm);
      ata_iordy = 1'b1;
      @(negedge clk);
      chk({nm, "_idle_after"}, {bus_if.bus_wait, ata_cs0_n, ata_cs1_n, dut.oe_q}, 4'b0110);
   endtask

   initial begin
      int k, done_cnt, last;
      logic prev_dior;
      bus_if.bus_en = 1'b0; bus_if.bus_wr = 1'b0; bus_if.bus_addr = '0; bus_if.bus_din = '0;
      vecs[0] = '{1'b0, 4'b0110, 16'h0000, 16'h0050, 5'b10_110, 16'h0050};
      vecs[1] = '{1'b1, 4'b1111, 16'h00EC, 16'h0000, 5'b01_111, 16'h0050};
      vecs[2] = '{1'b0, 4'b1010, 16'h0000, 16'hBEEF, 5'b01_010, 16'hBEEF};
      vecs[3] = '{1'b1, 4'b0011, 16'h1234, 16'h0000, 5'b10_011, 16'hBEEF};
      vecs[4] = '{1'b0, 4'b1000, 16'h0000, 16'hFFFF, 5'b01_000, 16'hFFFF};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_pins", {ata_cs0_n, ata_cs1_n, ata_dior_n, ata_diow_n, ata_a},
          {4'b1111, 3'b000});
      chk("reset_oe", dut.oe_q, 0);
      chk("reset_dout", bus_if.bus_dout, 0);
      chk("reset_wait", bus_if.bus_wait, 0);

      // Table of single cycles with IORDY ready.
      for (int i = 0; i < 5; i++) begin
         sb.push_back(vecs[i].exp_dout);
         run_cycle(vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].dev, vecs[i].exp_csa,
                   0, 15, 31, $sformatf("vec%0d", i));
      end
      model_dout = 16'hFFFF;

      // IORDY low for 20 clocks: three extension clocks.
      model_dout = 16'h1357;
      sb.push_back(model_dout);
      run_cycle(1'b0, 4'b1000, 16'h0, 16'h1357, 5'b01_000, 1, 18, 34, "iordy_ext");

      // IORDY stuck low: extension capped at the timeout.
      model_dout = 16'h2468;
      sb.push_back(model_dout);
      run_cycle(1'b0, 4'b1001, 16'h0, 16'h2468, 5'b01_001, 2, 77, 93, "iordy_tmo");

      // Back-to-back data-register reads with bus_en held high.
      dev_word = 16'd1;
      sb.push_back(16'd1); sb.push_back(16'd2); sb.push_back(16'd3);
      bus_if.bus_en = 1'b1; bus_if.bus_wr = 1'b0; bus_if.bus_addr = 4'b1000;
      k = 0; done_cnt = 0; last = 0; prev_dior = 1'b1;
      while (done_cnt < 3 && k < 200) begin
         @(negedge clk);
         k++;
         if (ata_dior_n && !prev_dior) dev_word = dev_word + 16'd1;
         prev_dior = ata_dior_n;
         if (!bus_if.bus_wait) begin
            done_cnt++;
            pop_chk($sformatf("b2b%0d", done_cnt));
            if (done_cnt > 1) chk($sformatf("b2b_gap%0d", done_cnt), k - last, 33);
            last = k;
            if (done_cnt == 3) bus_if.bus_en = 1'b0;
         end
      end
      chk("b2b_count", done_cnt, 3);
      repeat (2) @(negedge clk);
      chk("b2b_stop", {bus_if.bus_wait, ata_cs0_n, ata_cs1_n}, 3'b011);
      model_dout = 16'd3;

      // Reset while a write strobe is active.
      bus_if.bus_en = 1'b1; bus_if.bus_wr = 1'b1; bus_if.bus_addr = 4'b1001;
      bus_if.bus_din = 16'h5555;
      @(posedge clk);
      @(negedge clk);
      bus_if.bus_en = 1'b0;
      k = 0;
      while (ata_diow_n && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("rst_reached_strobe", ata_diow_n, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_strobes", {ata_dior_n, ata_diow_n}, 2'b11);
      chk("rst_cs", {ata_cs0_n, ata_cs1_n}, 2'b11);
      chk("rst_oe", dut.oe_q, 0);
      chk("rst_wait_lo", bus_if.bus_wait, bus_if.bus_en);
      bus_if.bus_en = 1'b1;
      #1;
      chk("rst_wait_hi", bus_if.bus_wait, bus_if.bus_en);
      bus_if.bus_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_dout = 16'h0000;
      @(negedge clk);
      chk("rst_dout", bus_if.bus_dout, model_dout);
      model_dout = 16'hA5C3;
      sb.push_back(model_dout);
      run_cycle(1'b0, 4'b0110, 16'h0, 16'hA5C3, 5'b10_110, 0, 15, 31, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
